alu_sequencer: RTL and testbench

Multi-cycle controller that sequences the basic RV32 ALU (`alu_basica`: add, sub, and, or, xor, jal).
- Fetches instructions over a simple request/ready instruction-memory port.
- Decodes and legality-checks each instruction.
- Reads operands from an internal 32×32 register file and issues one operation to the ALU with a single-cycle `valid` pulse.
- Waits for `result_valid`, writes `rd` back and advances `pc` from the ALU's `next_pc`.
- Sits between instruction memory and the ALU as the minimal core control path.

---
 rtl/seq_pkg.sv | 48 ++++
 rtl/regfile_32x32.sv | 38 +++
 rtl/alu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and encodings for the ALU sequencer: FSM states, the RV32 opcode
// and function fields it accepts, and the error codes it reports.
package seq_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        READ,
        ISSUE,
        WAIT,
        WB,
        HALT
    } seq_state_t;

    localparam logic [6:0] OPC_OP  = 7'h33;
    localparam logic [6:0] OPC_JAL = 7'h6F;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Only the five register-register ops the ALU implements, plus jal.
    function automatic logic is_legal(input logic [31:0] instr);
        logic legal;
        legal = 1'b0;
        if (instr[6:0] == OPC_JAL) begin
            legal = 1'b1;
        end else if (instr[6:0] == OPC_OP) begin
            case (instr[14:12])
                F3_ADD_SUB: legal = (instr[31:25] == F7_BASE) || (instr[31:25] == F7_SUB);
                F3_XOR,
                F3_OR,
                F3_AND:     legal = (instr[31:25] == F7_BASE);
                default:    legal = 1'b0;
            endcase
        end
        return legal;
    endfunction

endpackage

// File: rtl/regfile_32x32.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write
// port, x0 hardwired to zero.
module regfile_32x32 (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem_q [1:31];
    logic [31:0] mem_d [1:31];

    // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != 5'd0)) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: the array is deliberately reset, since a reset must leave x1-x31 at zero architecturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : mem_q[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : mem_q[raddr2];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control path: fetch, decode, operand read, ALU issue, wait for
// the result, write back and advance pc. Any error parks the FSM in HALT.
module alu_sequencer
    import seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ALU_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        alu_valid,
    output logic [31:0] alu_instruction,
    output logic [31:0] alu_pc,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_next_pc,
    input  logic        alu_result_valid,
    input  logic        alu_is_jump,
    output logic        retire,
    output logic [31:0] retired_count,
    output logic        halted,
    output logic [1:0]  err_code
);

    seq_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] res_q, res_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] count_q, count_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] apc_q, apc_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [1:0]  err_q, err_d;

    logic        fetch_req;
    logic        rf_we;
    logic        is_jal;
    logic [31:0] rf_rdata1, rf_rdata2;

    // No jump counter is exposed on this block, so the ALU's jump flag has no consumer here.
    logic unused_is_jump;
    assign unused_is_jump = alu_is_jump;

    regfile_32x32 u_regfile (
        .clk    (clk),
        .resetn (resetn),
        .raddr1 (ir_q[19:15]),
        .rdata1 (rf_rdata1),
        .raddr2 (ir_q[24:20]),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (ir_q[11:7]),
        .wdata  (res_q)
    );

    assign is_jal = (ir_q[6:0] == OPC_JAL);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        res_d     = res_q;
        npc_d     = npc_q;
        timer_d   = timer_q;
        count_d   = count_q;
        instr_d   = instr_q;
        apc_d     = apc_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        err_d     = err_q;
        fetch_req = 1'b0;
        alu_valid = 1'b0;
        retire    = 1'b0;
        rf_we     = 1'b0;

        case (state_q)
            FETCH: begin
                fetch_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_legal(ir_q)) begin
                    state_d = READ;
                end else begin
                    err_d   = ERR_ILLEGAL;
                    state_d = HALT;
                end
            end
            READ: begin
                rs1_d   = is_jal ? 32'h0 : rf_rdata1;
                rs2_d   = is_jal ? 32'h0 : rf_rdata2;
                instr_d = ir_q;
                apc_d   = pc_q;
                state_d = ISSUE;
            end
            ISSUE: begin
                alu_valid = 1'b1;
                timer_d   = 32'h0;
                state_d   = WAIT;
            end
            WAIT: begin
                // A result in the same cycle the budget runs out still wins.
                if (alu_result_valid) begin
                    res_d   = alu_result;
                    npc_d   = alu_next_pc;
                    state_d = WB;
                end else if ((timer_q + 32'd1) >= ALU_TIMEOUT) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = HALT;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                pc_d    = npc_q;
                count_d = count_q + 32'd1;
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            res_q   <= '0;
            npc_q   <= '0;
            timer_q <= '0;
            count_q <= '0;
            instr_q <= '0;
            apc_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            npc_q   <= npc_d;
            timer_q <= timer_d;
            count_q <= count_d;
            instr_q <= instr_d;
            apc_q   <= apc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            err_q   <= err_d;
        end
    end

    // The FETCH state is the reset state, so the request is masked while reset is held.
    assign imem_req        = fetch_req && resetn;
    assign imem_addr       = pc_q;
    assign alu_instruction = instr_q;
    assign alu_pc          = apc_q;
    assign alu_rs1         = rs1_q;
    assign alu_rs2         = rs2_q;
    assign retired_count   = count_q;
    assign halted          = (state_q == HALT);
    assign err_code        = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, halt/reset
// sequences, then random programs checked against an architectural model.
module tb_alu_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        alu_valid, alu_result_valid = 1'b0, alu_is_jump = 1'b0;
    logic [31:0] alu_instruction, alu_pc, alu_rs1, alu_rs2;
    logic [31:0] alu_result = '0, alu_next_pc = '0;
    logic        retire, halted;
    logic [31:0] retired_count;
    logic [1:0]  err_code;

    alu_sequencer #(.RESET_PC(RESET_PC), .ALU_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .alu_valid(alu_valid), .alu_instruction(alu_instruction), .alu_pc(alu_pc),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_result(alu_result), .alu_next_pc(alu_next_pc),
        .alu_result_valid(alu_result_valid), .alu_is_jump(alu_is_jump),
        .retire(retire), .retired_count(retired_count), .halted(halted), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  stall;
        logic [3:0]  delay;
        logic        ov_en;
        logic [31:0] ov_val;
        logic        spur;
        logic [31:0] e_pc;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [7:0]  e_lat;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Architectural model state.
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_count;

    // ALU responder controls.
    bit          resp_en = 1'b1;
    int          resp_delay = 0;
    bit          ov_en = 1'b0;
    logic [31:0] ov_val = '0;
    logic [31:0] resp_r, resp_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input int rs2, input int rs1,
                                           input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] jal_enc(input int rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'h6F};
    endfunction

    function automatic logic [31:0] jal_imm(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic bit ref_legal(input logic [31:0] i);
        if (i[6:0] == 7'h6F) return 1'b1;
        if (i[6:0] != 7'h33) return 1'b0;
        case ({i[14:12], i[31:25]})
            {3'd0, 7'h00}, {3'd0, 7'h20}, {3'd7, 7'h00}, {3'd6, 7'h00}, {3'd4, 7'h00}: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] i, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] pc);
        if (i[6:0] == 7'h6F) return pc + 32'd4;
        case (i[14:12])
            3'd0:    return i[30] ? a - b : a + b;
            3'd4:    return a ^ b;
            3'd6:    return a | b;
            3'd7:    return a & b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_next_pc(input logic [31:0] i, input logic [31:0] pc);
        return (i[6:0] == 7'h6F) ? pc + jal_imm(i) : pc + 32'd4;
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input int stall, input int delay,
                                input bit oe, input logic [31:0] ov, input bit spur,
                                input logic [31:0] e_pc, input logic [31:0] e_rs1,
                                input logic [31:0] e_rs2, input int e_lat);
        vec_t v;
        v.instr = instr;  v.stall = 4'(stall); v.delay = 4'(delay);
        v.ov_en = oe;     v.ov_val = ov;       v.spur = spur;
        v.e_pc = e_pc;    v.e_rs1 = e_rs1;     v.e_rs2 = e_rs2; v.e_lat = 8'(e_lat);
        return v;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_pc    = RESET_PC;
        m_count = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"},   32'(imem_req), 32'h0);
        check({tag, "_imem_addr"},  imem_addr, RESET_PC);
        check({tag, "_alu_valid"},  32'(alu_valid), 32'h0);
        check({tag, "_alu_instr"},  alu_instruction, 32'h0);
        check({tag, "_alu_pc"},     alu_pc, 32'h0);
        check({tag, "_alu_rs1"},    alu_rs1, 32'h0);
        check({tag, "_alu_rs2"},    alu_rs2, 32'h0);
        check({tag, "_retire"},     32'(retire), 32'h0);
        check({tag, "_retired"},    retired_count, 32'h0);
        check({tag, "_halted"},     32'(halted), 32'h0);
        check({tag, "_err"},        32'(err_code), 32'h0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        m_reset();
        #1 check("rst_req_after_release", 32'(imem_req), 32'h1);
    endtask

    // Registered ALU model: answers one cycle after the issue strobe, plus resp_delay.
    initial begin
        forever begin
            @(negedge clk);
            if (alu_valid && resp_en) begin
                resp_r = ov_en ? ov_val : ref_result(alu_instruction, alu_rs1, alu_rs2, alu_pc);
                resp_n = ref_next_pc(alu_instruction, alu_pc);
                repeat (resp_delay) @(posedge clk);
                @(posedge clk);
                #1;
                alu_result_valid = 1'b1;
                alu_result       = resp_r;
                alu_next_pc      = resp_n;
                alu_is_jump      = (alu_instruction[6:0] == 7'h6F);
                @(posedge clk);
                #1;
                alu_result_valid = 1'b0;
                alu_result       = $urandom;
                alu_next_pc      = $urandom;
                alu_is_jump      = 1'b0;
            end
        end
    end

    // Runs one instruction from its FETCH cycle; lat counts cycles up to retire or halt.
    task automatic exec(input vec_t v, output int lat, output bit halt_seen, output bit saw_valid,
                        output logic [31:0] o_rs1, output logic [31:0] o_rs2, output logic [31:0] o_pc);
        logic [31:0] e_rs1, e_rs2, e_res, e_npc;
        bit          jal, done, retired;
        int          stall;
        jal   = (v.instr[6:0] == 7'h6F);
        e_rs1 = jal ? 32'h0 : m_regs[v.instr[19:15]];
        e_rs2 = jal ? 32'h0 : m_regs[v.instr[24:20]];
        e_res = v.ov_en ? v.ov_val : ref_result(v.instr, e_rs1, e_rs2, m_pc);
        e_npc = ref_next_pc(v.instr, m_pc);
        stall = int'(v.stall);
        resp_delay = int'(v.delay);
        ov_en      = v.ov_en;
        ov_val     = v.ov_val;
        imem_rdata = v.instr;
        lat = 0; halt_seen = 0; saw_valid = 0; done = 0; retired = 0;
        o_rs1 = 32'h0; o_rs2 = 32'h0; o_pc = 32'h0;
        for (int n = 1; n <= 64 && !done; n++) begin
            @(negedge clk);
            if (n <= stall + 1) begin
                check("fetch_req", 32'(imem_req), 32'h1);
                check("fetch_addr", imem_addr, m_pc);
            end
            imem_ready = (n == stall + 1);
            if (v.spur && n == stall + 2) begin
                alu_result_valid = 1'b1;
                alu_result       = 32'hDEAD_BEEF;
                alu_next_pc      = 32'hBAD0_0000;
            end
            if (v.spur && n == stall + 3) alu_result_valid = 1'b0;
            if (alu_valid) begin
                saw_valid = 1;
                o_rs1 = alu_rs1; o_rs2 = alu_rs2; o_pc = alu_pc;
                check("issue_rs1", alu_rs1, e_rs1);
                check("issue_rs2", alu_rs2, e_rs2);
                check("issue_pc", alu_pc, m_pc);
                check("issue_instr", alu_instruction, v.instr);
            end
            if (retire) begin retired = 1; done = 1; lat = n; end
            if (halted) begin halt_seen = 1; done = 1; lat = n; end
        end
        imem_ready = 1'b0;
        if (!done) check("exec_cycle_bound", 32'h0, 32'h1);
        if (retired) begin
            if (v.instr[11:7] != 5'd0) m_regs[v.instr[11:7]] = e_res;
            m_pc = e_npc;
            m_count++;
            @(posedge clk);
            #1 check("retired_count", retired_count, m_count);
        end
    endtask

    task automatic check_sticky_halt(input logic [1:0] err);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("halt_sticky", 32'(halted), 32'h1);
            check("halt_err", 32'(err_code), 32'(err));
            check("halt_no_issue", 32'(alu_valid | retire | imem_req), 32'h0);
            check("halt_count", retired_count, m_count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [16];
        vec_t        v;
        logic [9:0]  ops [5];
        logic [31:0] o_rs1, o_rs2, o_pc;
        int          lat;
        bit          hs, sv, found;

        tbl[0]  = mk(r_type(7'h00, 0, 0, 3'd0, 1), 0, 0, 1, 32'd15, 0, 32'h00, 32'h0, 32'h0, 6);
        tbl[1]  = mk(r_type(7'h00, 0, 0, 3'd0, 2), 0, 0, 1, 32'd20, 0, 32'h04, 32'h0, 32'h0, 6);
        tbl[2]  = mk(r_type(7'h00, 2, 1, 3'd0, 2), 0, 0, 0, 32'h0,  0, 32'h08, 32'd15, 32'd20, 6);
        tbl[3]  = mk(r_type(7'h00, 0, 2, 3'd0, 9), 0, 0, 0, 32'h0,  0, 32'h0C, 32'd35, 32'h0, 6);
        tbl[4]  = mk(r_type(7'h00, 0, 0, 3'd0, 1), 0, 0, 1, 32'd10, 0, 32'h10, 32'h0, 32'h0, 6);
        tbl[5]  = mk(r_type(7'h00, 0, 0, 3'd0, 2), 0, 0, 1, 32'd20, 0, 32'h14, 32'h0, 32'h0, 6);
        tbl[6]  = mk(32'h402081B3,                 0, 0, 0, 32'h0,  0, 32'h18, 32'd10, 32'd20, 6);
        tbl[7]  = mk(r_type(7'h00, 0, 3, 3'd0, 4), 0, 0, 0, 32'h0,  0, 32'h1C, 32'hFFFF_FFF6, 32'h0, 6);
        tbl[8]  = mk(r_type(7'h00, 0, 0, 3'd0, 1), 0, 0, 1, 32'hFFFF_0000, 0, 32'h20, 32'h0, 32'h0, 6);
        tbl[9]  = mk(r_type(7'h00, 0, 0, 3'd0, 2), 0, 0, 1, 32'h0000_FFFF, 0, 32'h24, 32'h0, 32'h0, 6);
        tbl[10] = mk(32'h0020C333,                 0, 0, 0, 32'h0,  0, 32'h28, 32'hFFFF_0000, 32'h0000_FFFF, 6);
        tbl[11] = mk(r_type(7'h00, 0, 6, 3'd0, 8), 0, 0, 0, 32'h0,  0, 32'h2C, 32'hFFFF_FFFF, 32'h0, 6);
        tbl[12] = mk(32'h008000EF,                 0, 0, 0, 32'h0,  0, 32'h30, 32'h0, 32'h0, 6);
        tbl[13] = mk(r_type(7'h00, 2, 1, 3'd0, 0), 3, 0, 0, 32'h0,  0, 32'h38, 32'h34, 32'h0000_FFFF, 9);
        tbl[14] = mk(r_type(7'h00, 1, 0, 3'd0, 10), 0, 0, 0, 32'h0, 1, 32'h3C, 32'h0, 32'h34, 6);
        tbl[15] = mk(r_type(7'h00, 6, 8, 3'd0, 11), 0, 2, 0, 32'h0, 0, 32'h40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8);

        ops[0] = 10'h000; ops[1] = 10'h020; ops[2] = 10'h380; ops[3] = 10'h300; ops[4] = 10'h200;

        m_reset();
        apply_reset();

        for (int i = 0; i < 16; i++) begin
            exec(tbl[i], lat, hs, sv, o_rs1, o_rs2, o_pc);
            check($sformatf("vec%0d_issued", i), 32'(sv), 32'h1);
            check($sformatf("vec%0d_pc", i), o_pc, tbl[i].e_pc);
            check($sformatf("vec%0d_rs1", i), o_rs1, tbl[i].e_rs1);
            check($sformatf("vec%0d_rs2", i), o_rs2, tbl[i].e_rs2);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].e_lat));
        end
        check("vec_final_count", retired_count, 32'd16);
        check("vec_final_addr", imem_addr, 32'h44);

        // Illegal funct3=5 on an OP instruction.
        exec(mk(32'h0020D233, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0), lat, hs, sv, o_rs1, o_rs2, o_pc);
        check("illegal_halt", 32'(hs), 32'h1);
        check("illegal_no_issue", 32'(sv), 32'h0);
        check("illegal_latency", 32'(lat), 32'd3);
        check_sticky_halt(2'b01);
        apply_reset();

        // ALU that never answers.
        resp_en = 1'b0;
        exec(mk(r_type(7'h00, 1, 1, 3'd0, 1), 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0), lat, hs, sv, o_rs1, o_rs2, o_pc);
        check("timeout_halt", 32'(hs), 32'h1);
        check("timeout_issued", 32'(sv), 32'h1);
        check("timeout_latency", 32'(lat), 32'(4 + TIMEOUT + 1));
        check_sticky_halt(2'b10);
        resp_en = 1'b1;
        apply_reset();

        // Reset while waiting on the ALU: x5 must not receive the in-flight result.
        exec(mk(r_type(7'h00, 0, 0, 3'd0, 5), 0, 0, 1, 32'h0000_ABCD, 0, 32'h0, 32'h0, 32'h0, 0), lat, hs, sv, o_rs1, o_rs2, o_pc);
        resp_en = 1'b0;
        imem_rdata = r_type(7'h00, 5, 5, 3'd0, 5);
        found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            imem_ready = imem_req;
            if (alu_valid) found = 1;
        end
        imem_ready = 1'b0;
        check("rwait_issue_seen", 32'(found), 32'h1);
        check("rwait_rs1", alu_rs1, 32'h0000_ABCD);
        @(negedge clk);
        check("rwait_in_wait", 32'(retire | halted), 32'h0);
        resetn = 1'b0;
        #1 check_reset_outputs("rwait");
        @(negedge clk);
        resetn = 1'b1;
        m_reset();
        resp_en = 1'b1;
        exec(mk(r_type(7'h00, 5, 5, 3'd0, 12), 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0), lat, hs, sv, o_rs1, o_rs2, o_pc);
        check("rwait_restart_pc", o_pc, RESET_PC);
        check("rwait_x5_cleared", o_rs1, 32'h0);
        check("rwait_restart_count", retired_count, 32'd1);

        // Random legal programs against the architectural model.
        for (int i = 0; i < 150; i++) begin
            int          k, stall, delay;
            logic [31:0] instr;
            k     = $urandom_range(0, 5);
            stall = $urandom_range(0, 2);
            delay = $urandom_range(0, 2);
            if (k == 5) instr = jal_enc($urandom_range(0, 31), 21'($urandom) & 21'h1F_FFFE);
            else instr = r_type(ops[k][6:0], $urandom_range(0, 31), $urandom_range(0, 31),
                                ops[k][9:7], $urandom_range(0, 31));
            v = mk(instr, stall, delay, $urandom_range(0, 1) == 1, $urandom,
                   $urandom_range(0, 3) == 0, 32'h0, 32'h0, 32'h0, 0);
            exec(v, lat, hs, sv, o_rs1, o_rs2, o_pc);
            check("rand_no_halt", 32'(hs), 32'h0);
            check("rand_latency", 32'(lat), 32'(6 + stall + delay));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
